// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : game_pkg
//  Description : Shared game-state enum, gameplay constants and a popcount
//                helper for the game state sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_PLAYING     = 3'd1,
    ST_PLAYER_HIT  = 3'd2,
    ST_LEVEL_CLEAR = 3'd3,
    ST_GAME_OVER   = 3'd4
  } game_state_t;

  localparam int unsigned C_LIVES_INIT       = 3;
  localparam int unsigned C_POINTS_PER_ALIEN = 10;
  localparam int unsigned C_SCORE_W          = 14;
  localparam int unsigned C_HIT_FRAMES       = 60;
  localparam int unsigned C_CLEAR_FRAMES     = 90;
  localparam int unsigned C_GOD_FRAMES       = 300;
  localparam int unsigned C_TURBO_FRAMES     = 300;
  localparam int unsigned C_MAX_LEVEL        = 7;

  // Wide enough for the longest frame duration above
  localparam int unsigned C_TIMER_W          = 9;

  // Number of player rockets that hit an alien in one frame
  function automatic logic [1:0] popcount(input logic [1:0] v);
    return 2'(v[0]) + 2'(v[1]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/game_state_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : game_state_sequencer_if
//  Description : Collision inputs and game-status outputs of the sequencer.
//                master = collision/control source, slave = sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface game_state_sequencer_if
  import game_pkg::*;
#(
  parameter int unsigned SCORE_W = C_SCORE_W
);
  // Collision detector / control side
  logic               startOfFrame;
  logic               startGame;
  logic               allAliensDead;
  logic [1:0]         alienHit;
  logic               playerHitByAlienPulse;
  logic [2:0]         playerHitByRocket;
  logic               PlayerHitBy_h_Rocket;
  logic               aliensReachedBorder;
  logic               TurboCollision;
  logic               GodModeCollision;

  // Game status side
  logic [2:0]         gameState;
  logic               runEnable;
  logic [2:0]         lives;
  logic [SCORE_W-1:0] score;
  logic [2:0]         level;
  logic               godModeActive;
  logic               turboActive;
  logic [1:0]         rocketKill;
  logic               playerExplode;

  modport master (
    output startOfFrame, startGame, allAliensDead, alienHit,
           playerHitByAlienPulse, playerHitByRocket, PlayerHitBy_h_Rocket,
           aliensReachedBorder, TurboCollision, GodModeCollision,
    input  gameState, runEnable, lives, score, level,
           godModeActive, turboActive, rocketKill, playerExplode
  );

  modport slave (
    input  startOfFrame, startGame, allAliensDead, alienHit,
           playerHitByAlienPulse, playerHitByRocket, PlayerHitBy_h_Rocket,
           aliensReachedBorder, TurboCollision, GodModeCollision,
    output gameState, runEnable, lives, score, level,
           godModeActive, turboActive, rocketKill, playerExplode
  );

endinterface
`default_nettype wire

// File: rtl/frame_down_timer.sv
`default_nettype none
// ============================================================================
//  Module      : frame_down_timer
//  Description : Loadable down-counter stepped once per frame. Stops at zero.
//                o_active = count nonzero, o_last = count is one (next
//                enabled tick reaches zero).
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_down_timer #(
  parameter int unsigned W = 9
) (
  input  wire          clk,
  input  wire          resetN,
  input  wire          i_load,
  input  wire  [W-1:0] i_load_val,
  input  wire          i_tick,
  input  wire          i_en,
  output logic         o_active,
  output logic         o_last
);

  logic [W-1:0] r_count;

  // Load wins over counting; counting only on enabled ticks and never below 0
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_tick && i_en && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_active = (r_count != '0);
  assign o_last   = (r_count == W'(1));

endmodule
`default_nettype wire

// File: rtl/game_state_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : game_state_sequencer
//  Description : Collects per-pixel collision flags over a frame and commits
//                them on startOfFrame: score, lives, level, power-up timers
//                and the top-level game state.
//  Revision    : 1.0 - initial release
// ============================================================================
module game_state_sequencer
  import game_pkg::*;
#(
  parameter int unsigned LIVES_INIT       = C_LIVES_INIT,
  parameter int unsigned POINTS_PER_ALIEN = C_POINTS_PER_ALIEN,
  parameter int unsigned SCORE_W          = C_SCORE_W,
  parameter int unsigned HIT_FRAMES       = C_HIT_FRAMES,
  parameter int unsigned CLEAR_FRAMES     = C_CLEAR_FRAMES,
  parameter int unsigned GOD_FRAMES       = C_GOD_FRAMES,
  parameter int unsigned TURBO_FRAMES     = C_TURBO_FRAMES,
  parameter int unsigned MAX_LEVEL        = C_MAX_LEVEL
) (
  input wire                   clk,
  input wire                   resetN,
  game_state_sequencer_if.slave gs
);

  // ---------------------------------------------------------------- state
  game_state_t          r_state, w_state_nxt;
  logic [2:0]           r_lives, w_lives_nxt;
  logic [SCORE_W-1:0]   r_score, w_score_nxt;
  logic [2:0]           r_level, w_level_nxt;
  logic [1:0]           r_kill,  w_kill_nxt;
  logic                 r_explode, w_explode_nxt;

  // Sticky per-frame collision flags
  logic [1:0]           r_hitR;
  logic                 r_plyHit, r_border, r_godPick, r_turboPick;

  // Flags including this clock's inputs, so a frame-boundary hit is kept
  logic [1:0]           w_hitR;
  logic                 w_plyHit, w_border, w_godPick, w_turboPick;
  logic                 w_commit, w_init;

  // Timer controls / status
  logic                 w_frame_load, w_god_load, w_turbo_load;
  logic [C_TIMER_W-1:0] w_frame_val, w_god_val, w_turbo_val;
  logic                 w_frame_active, w_frame_last;
  logic                 w_god_active, w_god_last;
  logic                 w_turbo_active, w_turbo_last;
  logic                 w_frame_done;
  logic                 w_unused_ok;

  logic [SCORE_W:0]     w_score_sum;
  logic [SCORE_W-1:0]   w_score_sat;

  assign w_hitR      = r_hitR | gs.alienHit;
  assign w_plyHit    = r_plyHit | gs.playerHitByAlienPulse
                     | (|gs.playerHitByRocket) | gs.PlayerHitBy_h_Rocket;
  assign w_border    = r_border    | gs.aliensReachedBorder;
  assign w_godPick   = r_godPick   | gs.GodModeCollision;
  assign w_turboPick = r_turboPick | gs.TurboCollision;

  assign w_commit    = gs.startOfFrame;
  assign w_init      = gs.startGame
                     && ((r_state == ST_IDLE) || (r_state == ST_GAME_OVER));

  // Carry out of the add marks overflow; adds never exceed 2^SCORE_W
  assign w_score_sum = {1'b0, r_score}
                     + (SCORE_W+1)'(POINTS_PER_ALIEN * popcount(w_hitR));
  assign w_score_sat = w_score_sum[SCORE_W] ? '1 : w_score_sum[SCORE_W-1:0];

  // Hold / pause period finishes on the commit that takes frameCnt to zero
  assign w_frame_done = w_frame_last || !w_frame_active;

  // Terminal-count flags of the power-up timers are not needed here
  assign w_unused_ok  = &{1'b0, w_god_last, w_turbo_last};

  // Accumulate collisions; a commit or game start consumes and clears them
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_hitR      <= '0;
      r_plyHit    <= 1'b0;
      r_border    <= 1'b0;
      r_godPick   <= 1'b0;
      r_turboPick <= 1'b0;
    end else if (w_commit || w_init) begin
      r_hitR      <= '0;
      r_plyHit    <= 1'b0;
      r_border    <= 1'b0;
      r_godPick   <= 1'b0;
      r_turboPick <= 1'b0;
    end else begin
      r_hitR      <= w_hitR;
      r_plyHit    <= w_plyHit;
      r_border    <= w_border;
      r_godPick   <= w_godPick;
      r_turboPick <= w_turboPick;
    end
  end

  // Game state and status registers
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state   <= ST_IDLE;
      r_lives   <= '0;
      r_score   <= '0;
      r_level   <= 3'd1;
      r_kill    <= '0;
      r_explode <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_lives   <= w_lives_nxt;
      r_score   <= w_score_nxt;
      r_level   <= w_level_nxt;
      r_kill    <= w_kill_nxt;
      r_explode <= w_explode_nxt;
    end
  end

  // Next-state, commit arithmetic and timer load decisions
  always_comb begin
    w_state_nxt   = r_state;
    w_lives_nxt   = r_lives;
    w_score_nxt   = r_score;
    w_level_nxt   = r_level;
    w_kill_nxt    = '0;
    w_explode_nxt = 1'b0;
    w_frame_load  = 1'b0;
    w_frame_val   = '0;
    w_god_load    = 1'b0;
    w_god_val     = '0;
    w_turbo_load  = 1'b0;
    w_turbo_val   = '0;

    case (r_state)
      ST_IDLE, ST_GAME_OVER: begin
        if (gs.startGame) begin
          w_state_nxt  = ST_PLAYING;
          w_lives_nxt  = 3'(LIVES_INIT);
          w_score_nxt  = '0;
          w_level_nxt  = 3'd1;
          w_frame_load = 1'b1;
          w_god_load   = 1'b1;
          w_turbo_load = 1'b1;
        end
      end

      ST_PLAYING: begin
        if (w_commit) begin
          w_score_nxt = w_score_sat;
          w_kill_nxt  = w_hitR;
          // Reload applies after this commit; protection uses the old timer
          if (w_godPick) begin
            w_god_load = 1'b1;
            w_god_val  = C_TIMER_W'(GOD_FRAMES);
          end
          if (w_turboPick) begin
            w_turbo_load = 1'b1;
            w_turbo_val  = C_TIMER_W'(TURBO_FRAMES);
          end
          if (w_border) begin
            w_state_nxt = ST_GAME_OVER;
          end else if (w_plyHit && !w_god_active) begin
            w_lives_nxt   = (r_lives != 3'd0) ? (r_lives - 3'd1) : 3'd0;
            w_explode_nxt = 1'b1;
            if (r_lives <= 3'd1) begin
              w_state_nxt = ST_GAME_OVER;
            end else begin
              w_state_nxt  = ST_PLAYER_HIT;
              w_frame_load = 1'b1;
              w_frame_val  = C_TIMER_W'(HIT_FRAMES);
            end
          end else if (gs.allAliensDead) begin
            w_state_nxt  = ST_LEVEL_CLEAR;
            w_frame_load = 1'b1;
            w_frame_val  = C_TIMER_W'(CLEAR_FRAMES);
          end
        end
      end

      ST_PLAYER_HIT: begin
        if (w_commit && w_frame_done) begin
          w_state_nxt = ST_PLAYING;
        end
      end

      ST_LEVEL_CLEAR: begin
        if (w_commit && w_frame_done) begin
          w_state_nxt = ST_PLAYING;
          w_level_nxt = (r_level >= 3'(MAX_LEVEL)) ? r_level : (r_level + 3'd1);
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  frame_down_timer #(.W(C_TIMER_W)) u_frame_cnt (
    .clk        (clk),
    .resetN     (resetN),
    .i_load     (w_frame_load),
    .i_load_val (w_frame_val),
    .i_tick     (w_commit),
    .i_en       ((r_state == ST_PLAYER_HIT) || (r_state == ST_LEVEL_CLEAR)),
    .o_active   (w_frame_active),
    .o_last     (w_frame_last)
  );

  frame_down_timer #(.W(C_TIMER_W)) u_god_timer (
    .clk        (clk),
    .resetN     (resetN),
    .i_load     (w_god_load),
    .i_load_val (w_god_val),
    .i_tick     (w_commit),
    .i_en       (r_state == ST_PLAYING),
    .o_active   (w_god_active),
    .o_last     (w_god_last)
  );

  frame_down_timer #(.W(C_TIMER_W)) u_turbo_timer (
    .clk        (clk),
    .resetN     (resetN),
    .i_load     (w_turbo_load),
    .i_load_val (w_turbo_val),
    .i_tick     (w_commit),
    .i_en       (r_state == ST_PLAYING),
    .o_active   (w_turbo_active),
    .o_last     (w_turbo_last)
  );

  assign gs.gameState     = r_state;
  assign gs.runEnable     = (r_state == ST_PLAYING);
  assign gs.lives         = r_lives;
  assign gs.score         = r_score;
  assign gs.level         = r_level;
  assign gs.godModeActive = w_god_active;
  assign gs.turboActive   = w_turbo_active;
  assign gs.rocketKill    = r_kill;
  assign gs.playerExplode = r_explode;

endmodule
`default_nettype wire

// File: doc/game_state_sequencer.md
Name: game_state_sequencer

Overview:
- Sequences game play from the per-pixel collision flags produced by the collision detector.
- Accumulates each frame's collision events into sticky flags, then commits them once per frame on startOfFrame. The commit updates score, lives, level, power-up timers and the top-level game state.
- Sits between the collision detector and the object/graphics blocks. Its outputs freeze movement, gate rocket firing and select screen overlays.

Parameters:
- LIVES_INIT, 3, lives loaded at game start (1..7)
- POINTS_PER_ALIEN, 10, score added per distinct alien hit per frame
- SCORE_W, 14, score width; score saturates at 2^SCORE_W-1
- HIT_FRAMES, 60, frames spent in PLAYER_HIT (invulnerable, frozen)
- CLEAR_FRAMES, 90, frames spent in LEVEL_CLEAR
- GOD_FRAMES, 300, god-mode duration in frames
- TURBO_FRAMES, 300, turbo duration in frames
- MAX_LEVEL, 7, level saturation value

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-clock pulse per frame
- startGame  in  1  one-clock key pulse
- allAliensDead  in  1  level-sensitive, from alien matrix
- alienHit  in  2  per-player-rocket alien collision (per pixel)
- playerHitByAlienPulse  in  1  alien/player collision pulse
- playerHitByRocket  in  3  per-alien-rocket player collision
- PlayerHitBy_h_Rocket  in  1  homing-rocket hit
- aliensReachedBorder  in  1  aliens at bottom border
- TurboCollision  in  1  turbo pickup
- GodModeCollision  in  1  god-mode pickup
- gameState  out  3  IDLE=0, PLAYING=1, PLAYER_HIT=2, LEVEL_CLEAR=3, GAME_OVER=4
- runEnable  out  1  1 only in PLAYING; movers freeze when 0
- lives  out  3  remaining lives
- score  out  SCORE_W  saturating score
- level  out  3  current level, 1..MAX_LEVEL
- godModeActive  out  1  god-mode timer nonzero
- turboActive  out  1  turbo timer nonzero
- rocketKill  out  2  one-clock pulse, bit i = player rocket i consumed this frame
- playerExplode  out  1  one-clock pulse on a committed player hit

Behaviour:
- Reset values: all outputs 0, except level=1 and gameState=IDLE. All sticky flags, timers and frame counters are 0.
- Sticky capture: on every clk, OR the inputs into the sticky flags: hitR[1:0], plyHit, border, godPick, turboPick.
  - plyHit = playerHitByAlienPulse | (|playerHitByRocket) | PlayerHitBy_h_Rocket.
  - On a startOfFrame clock, the flags are sampled with that clock's inputs ORed in, then cleared. Nothing is lost at the frame boundary.
- Commit occurs on the startOfFrame clock. Outputs update one clock later, i.e. registered.
- IDLE:
  - startGame loads lives=LIVES_INIT, score=0, level=1, clears both timers, and moves to PLAYING.
  - Collisions are ignored.
- PLAYING, commit priority (highest first):
  1. border -> GAME_OVER. God mode does not block this.
  2. plyHit && !godModeActive -> lives-1, playerExplode pulse. Go to GAME_OVER if lives becomes 0, else to PLAYER_HIT with frameCnt=HIT_FRAMES.
  3. allAliensDead -> LEVEL_CLEAR with frameCnt=CLEAR_FRAMES.
- Every PLAYING commit, regardless of the branch taken:
  - score += POINTS_PER_ALIEN * popcount(hitR), saturating.
  - rocketKill = hitR.
- PLAYER_HIT and LEVEL_CLEAR:
  - Collisions are discarded and runEnable=0.
  - frameCnt decrements on each commit. At 0:
    - PLAYER_HIT -> PLAYING.
    - LEVEL_CLEAR -> level+1 (saturates at MAX_LEVEL) -> PLAYING.
- GAME_OVER: holds until startGame, which performs the same initialisation as IDLE.
- Timers:
  - On a PLAYING commit, godPick reloads the god timer to GOD_FRAMES and turboPick reloads the turbo timer to TURBO_FRAMES. A retrigger reloads; durations do not accumulate.
  - Otherwise a nonzero timer decrements by 1 per commit, in PLAYING only; timers pause in the other states.
  - A pickup in the same commit as plyHit does not protect against that hit; the god flag is evaluated before reload.
- startGame in PLAYING, PLAYER_HIT or LEVEL_CLEAR is ignored.
- Asynchronous reset mid-game returns immediately to the reset values.

Decomposition:
- game_pkg holds:
  - the game_state_t enum (IDLE..GAME_OVER);
  - the LIVES_INIT, POINTS_PER_ALIEN and frame-duration constants;
  - a popcount function.
- One sub-module, frame_down_timer: a loadable per-frame down-counter with load, tick, enable and active/zero outputs. It is instantiated three times: frameCnt, god timer and turbo timer.

Test Plan:
- Start sequence: reset, then startGame -> gameState=1, lives=3, score=0, level=1, runEnable=1.
- Double hit: alienHit=2'b11 for 1 clk mid-frame, then startOfFrame -> score=20, rocketKill=2'b11 for exactly 1 clk.
- Player hit: playerHitByRocket=3'b010 held several pixels in one frame -> lives=2 (single decrement), state=2, runEnable=0. After 60 commits -> state=1.
- God mode: GodModeCollision then PlayerHitBy_h_Rocket 10 frames later -> lives unchanged, godModeActive=1. It falls to 0 exactly 300 PLAYING commits after pickup.
- Border priority: aliensReachedBorder, plyHit and allAliensDead all in the same frame -> state=4, lives unchanged. Then startGame -> state=1, lives=3.
- Level and saturation: allAliensDead at level 7 -> LEVEL_CLEAR for 90 frames, then level stays 7. Preload score near max -> score saturates at 16383.
